rv32_instr_encoder: RTL and testbench

Assembles RV32I instruction words from decoded fields: it is the encode-side inverse of the core's opcode/funct decoder. Field bundles arrive over a valid/ready handshake and leave as 32-bit words over a registered valid/ready output, feeding the instruction-memory loader and the self-test program generator. A load-immediate pseudo-op (`in_li`) expands into one or two words (LUI, then ADDI) under a small state machine.

---
 rtl/rv32_instr_encoder.sv | 156 +++++++++++++++
 tb/tb_rv32_instr_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs decoded RV32I fields into 32-bit instruction words.
// A load-immediate pseudo-op expands into ADDI, LUI, or LUI followed by ADDI.
// The output stage is fully registered; only in_ready is combinational.
module rv32_instr_encoder #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_op,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_6,
   input  logic [4:0]      in_rd,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_li,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic            out_last,
   output logic            out_err
);

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic {IDLE, EMIT2} state_t;

   state_t          state;
   logic [XLEN-1:0] pend_instr;

   logic [XLEN-1:0] enc_word;
   logic            enc_err;
   logic [6:0]      f7;
   logic            li_single;
   logic            li_two;
   logic [19:0]     li_hi;
   logic [XLEN-1:0] li_word0;
   logic [XLEN-1:0] li_addi;
   logic [XLEN-1:0] nxt_word;
   logic            nxt_last;
   logic            nxt_err;
   logic            accept;

   // A new bundle may enter only when no second LI word is pending and the
   // output register is empty or draining this cycle.
   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Format-specific field packing for ordinary (non-LI) bundles.
   always_comb begin
      enc_word = NOP;
      enc_err  = 1'b0;
      f7       = {1'b0, in_funct7_6, 5'b00000};
      case (in_op)
         OP_R:
            enc_word = {f7, in_rs2, in_rs1, in_funct3, in_rd, in_op, 2'b11};
         OP_IMM:
            // Shift-immediate forms carry funct7 and a 5-bit shamt.
            if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
               enc_word = {f7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op, 2'b11};
            else
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op, 2'b11};
         OP_LOAD:
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op, 2'b11};
         OP_JALR:
            enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_op, 2'b11};
         OP_STORE:
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op, 2'b11};
         OP_BRANCH:
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_op, 2'b11};
         OP_LUI, OP_AUIPC:
            enc_word = {in_imm[31:12], in_rd, in_op, 2'b11};
         OP_JAL:
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op, 2'b11};
         default: begin
            enc_word = NOP;
            enc_err  = 1'b1;
         end
      endcase
   end

   // LI split: the upper part is rounded up when ADDI's sign-extended low
   // 12 bits will subtract 4096.
   always_comb begin
      li_single = (&in_imm[31:11]) || (~|in_imm[31:11]);
      li_hi     = in_imm[31:12] + {19'd0, in_imm[11]};
      li_two    = !li_single && (|in_imm[11:0]);
      li_addi   = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM, 2'b11};
      if (li_single)
         li_word0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM, 2'b11};
      else
         li_word0 = {li_hi, in_rd, OP_LUI, 2'b11};
   end

   // Word presented to the output register on an accept.
   always_comb begin
      nxt_word = in_li ? li_word0 : enc_word;
      nxt_last = in_li ? !li_two : 1'b1;
      nxt_err  = !in_li && enc_err;
   end

   // Expansion FSM and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pend_instr <= '0;
         out_valid  <= 1'b0;
         out_instr  <= NOP;
         out_last   <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  out_instr <= nxt_word;
                  out_last  <= nxt_last;
                  out_err   <= nxt_err;
                  if (in_li && li_two) begin
                     pend_instr <= li_addi;
                     state      <= EMIT2;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            EMIT2: begin
               // The LUI is in the output register; swap in the ADDI once it drains.
               if (out_ready) begin
                  out_valid  <= 1'b1;
                  out_instr  <= pend_instr;
                  out_last   <= 1'b1;
                  out_err    <= 1'b0;
                  pend_instr <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Bench for rv32_instr_encoder: directed vectors plus randomized bundles
// checked against an arithmetic reference model of the RV32I formats.
module tb_rv32_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [2:0]  in_funct3;
   logic        in_funct7_6;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        in_li;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        out_err;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] got_w[$], exp_w[$];
   logic        got_l[$], exp_l[$];
   logic        got_e[$], exp_e[$];

   rv32_instr_encoder #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_funct3(in_funct3), .in_funct7_6(in_funct7_6),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .in_li(in_li),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_last(out_last), .out_err(out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit li, input logic [4:0] op, input logic [2:0] f3, input bit f76,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
      in_li = li; in_op = op; in_funct3 = f3; in_funct7_6 = f76;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
   endtask

   // Reference model: expected word list for one bundle, built from field
   // positions with shifts and masks; LI uses the signed value range and
   // round-to-nearest upper part.
   task automatic model(input bit li, input logic [4:0] op, input logic [2:0] f3, input bit f76,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
      logic [31:0] o, d, s1, s2, f, w, hi;
      bit err;
      exp_w.delete(); exp_l.delete(); exp_e.delete();
      o  = (32'(op) << 2) | 32'd3;
      d  = 32'(rd) << 7;
      s1 = 32'(rs1) << 15;
      s2 = 32'(rs2) << 20;
      f  = 32'(f3) << 12;
      err = 1'b0;
      if (li) begin
         if ($signed(imm) >= -2048 && $signed(imm) <= 2047) begin
            exp_w.push_back(((imm & 32'hFFF) << 20) | d | 32'h13);
            exp_l.push_back(1'b1); exp_e.push_back(1'b0);
         end else begin
            hi = ((imm + 32'h800) >> 12) & 32'hFFFFF;
            exp_w.push_back((hi << 12) | d | 32'h37);
            exp_l.push_back((imm & 32'hFFF) == 0); exp_e.push_back(1'b0);
            if ((imm & 32'hFFF) != 0) begin
               exp_w.push_back(((imm & 32'hFFF) << 20) | (32'(rd) << 15) | d | 32'h13);
               exp_l.push_back(1'b1); exp_e.push_back(1'b0);
            end
         end
         return;
      end
      case (op)
         5'b01100: w = (32'(f76) << 30) | s2 | s1 | f | d | o;
         5'b00100: w = (f3 == 3'd1 || f3 == 3'd5)
                       ? ((32'(f76) << 30) | ((imm & 32'h1F) << 20) | s1 | f | d | o)
                       : (((imm & 32'hFFF) << 20) | s1 | f | d | o);
         5'b00000: w = ((imm & 32'hFFF) << 20) | s1 | f | d | o;
         5'b11001: w = ((imm & 32'hFFF) << 20) | s1 | d | o;
         5'b01000: w = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | f | ((imm & 32'h1F) << 7) | o;
         5'b11000: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | f
                       | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
         5'b01101, 5'b00101: w = (imm & 32'hFFFFF000) | d | o;
         5'b11011: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 1) << 20) | (imm & 32'hFF000) | d | o;
         default: begin w = 32'h13; err = 1'b1; end
      endcase
      exp_w.push_back(w); exp_l.push_back(1'b1); exp_e.push_back(err);
   endtask

   // Issue one bundle with the consumer always ready and collect its words.
   task automatic do_req(input bit li, input logic [4:0] op, input logic [2:0] f3, input bit f76,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
      int n;
      got_w.delete(); got_l.delete(); got_e.delete();
      @(negedge clk);
      drive(li, op, f3, f76, rd, rs1, rs2, imm);
      in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 8) begin @(negedge clk); n++; end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (n < 6) begin
         if (out_valid) begin
            got_w.push_back(out_instr); got_l.push_back(out_last); got_e.push_back(out_err);
            if (!out_last) chk("in_ready_emit2", 32'(in_ready), 32'd0);
            else break;
         end
         @(negedge clk); n++;
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, "_count"}, 32'(got_w.size()), 32'(exp_w.size()));
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         chk({tag, "_word"}, got_w[i], exp_w[i]);
         chk({tag, "_last"}, 32'(got_l[i]), 32'(exp_l[i]));
         chk({tag, "_err"},  32'(got_e[i]), 32'(exp_e[i]));
      end
   endtask

   // Directed request with literal expected words from hand-encoded values.
   task automatic directed(input string tag, input bit li, input logic [4:0] op, input logic [2:0] f3,
                           input bit f76, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm,
                           input logic [31:0] w0, input logic [31:0] w1, input int nw,
                           input bit err);
      do_req(li, op, f3, f76, rd, rs1, rs2, imm);
      exp_w.delete(); exp_l.delete(); exp_e.delete();
      exp_w.push_back(w0); exp_l.push_back(nw == 1); exp_e.push_back(err);
      if (nw == 2) begin exp_w.push_back(w1); exp_l.push_back(1'b1); exp_e.push_back(1'b0); end
      compare(tag);
   endtask

   logic [4:0] ops [10] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                            5'b00101, 5'b01101, 5'b11011, 5'b11001, 5'b11111};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_instr", out_instr, 32'h13);
      chk("rst_last",  32'(out_last), 32'd0);
      chk("rst_err",   32'(out_err), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      directed("addi",  0, 5'b00100, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 0, 1, 0);
      directed("add",   0, 5'b01100, 3'd0, 0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 0, 1, 0);
      directed("sub",   0, 5'b01100, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 0, 1, 0);
      directed("beq",   0, 5'b11000, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 0, 1, 0);
      directed("jal",   0, 5'b11011, 3'd0, 0, 5'd1, 5'd0, 5'd0, -32'sd4, 32'hFFDFF0EF, 0, 1, 0);
      directed("li2",   1, 5'b11111, 3'd7, 1, 5'd5, 5'd9, 5'd9, 32'h12345678, 32'h123452B7, 32'h67828293, 2, 0);
      directed("licar", 1, 5'd0, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h00000800, 32'h000012B7, 32'h80028293, 2, 0);
      directed("lim1",  1, 5'd0, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00293, 0, 1, 0);
      directed("liup",  1, 5'd0, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 0, 1, 0);
      directed("badop", 0, 5'b11111, 3'd2, 1, 5'd7, 5'd3, 5'd4, 32'h1234, 32'h00000013, 0, 1, 1);

      // Back-to-back accepts: second word follows the first with no bubble.
      @(negedge clk);
      drive(0, 5'b00100, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_w0", out_instr, 32'h00500093);
      chk("b2b_rdy", 32'(in_ready), 32'd1);
      drive(0, 5'b01100, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_v1", 32'(out_valid), 32'd1);
      chk("b2b_w1", out_instr, 32'h402081B3);
      @(negedge clk);

      // Backpressure on the LUI of a two-word LI, with another bundle offered.
      drive(1, 5'd0, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345678);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      drive(0, 5'b00100, 3'd0, 0, 5'd9, 5'd0, 5'd0, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_word",  out_instr, 32'h123452B7);
         chk("bp_last",  32'(out_last), 32'd0);
         chk("bp_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp_addi", out_instr, 32'h67828293);
      chk("bp_alast", 32'(out_last), 32'd1);
      @(negedge clk);
      chk("bp_drain", 32'(out_valid), 32'd0);

      // Reset while the ADDI is pending.
      drive(1, 5'd0, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345678);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_lui", out_instr, 32'h123452B7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_instr", out_instr, 32'h13);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_no_addi", 32'(out_valid), 32'd0);
      end
      directed("post_rst", 0, 5'b00100, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 0, 1, 0);

      // Randomized bundles against the reference model.
      for (int t = 0; t < 80; t++) begin
         bit li;
         logic [4:0] op, rd, rs1, rs2;
         logic [2:0] f3;
         bit f76;
         logic [31:0] imm;
         li  = ($urandom_range(0, 2) == 0);
         op  = ops[$urandom_range(0, 9)];
         f3  = 3'($urandom);
         f76 = 1'($urandom);
         rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
         case ($urandom_range(0, 3))
            0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: imm = $urandom & 32'hFFFFF000;
            2: imm = (($urandom_range(0, 1) == 0) ? 32'h7FF : 32'hFFFFF800)
                     + 32'($urandom_range(0, 2)) - 32'd1;
            default: imm = $urandom;
         endcase
         do_req(li, op, f3, f76, rd, rs1, rs2, imm);
         model(li, op, f3, f76, rd, rs1, rs2, imm);
         compare(li ? "rnd_li" : "rnd_op");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
